// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and datapath widths for the dot-product MAC
package mac_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int OPW = 8;
    localparam int PRODW = 16;
endpackage

// File: rtl/dot_product_mac_if.sv
// dot_product_mac_if: operand-stream and result handshakes of the dot-product MAC
interface dot_product_mac_if #(parameter int ACC_W = 24, parameter int LEN_W = 8);
    import mac_pkg::*;
    logic start;
    logic [LEN_W-1:0] len;
    logic in_valid;
    logic in_ready;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic res_valid;
    logic res_ready;
    logic [ACC_W-1:0] result;
    logic overflow;
    logic busy;
    modport master (
        output start, len, in_valid, a, b, res_ready,
        input in_ready, res_valid, result, overflow, busy
    );
    modport slave (
        input start, len, in_valid, a, b, res_ready,
        output in_ready, res_valid, result, overflow, busy
    );
endinterface

// File: rtl/wallace.sv
// wallace: 8x8 unsigned combinational multiplier, carry-save tree plus final add
module wallace
    import mac_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] product
);
    logic [PRODW-1:0] pp [OPW];
    logic [2*PRODW-1:0] s0, s1, s2, s3, s4, s5;
    // 3:2 compressor on whole rows; carries past bit 15 cannot matter since the product fits 16 bits
    function automatic logic [2*PRODW-1:0] csa(input logic [PRODW-1:0] x, y, z);
        return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
    endfunction
    // partial product rows, row i is a shifted by i when b[i] is set
    always_comb begin
        for (int i = 0; i < OPW; i++) pp[i] = b[i] ? (PRODW'(a) << i) : '0;
    end
    assign s0 = csa(pp[0], pp[1], pp[2]);
    assign s1 = csa(pp[3], pp[4], pp[5]);
    assign s2 = csa(s0[PRODW-1:0], s0[2*PRODW-1:PRODW], s1[PRODW-1:0]);
    assign s3 = csa(s1[2*PRODW-1:PRODW], pp[6], pp[7]);
    assign s4 = csa(s2[PRODW-1:0], s2[2*PRODW-1:PRODW], s3[PRODW-1:0]);
    assign s5 = csa(s4[PRODW-1:0], s4[2*PRODW-1:PRODW], s3[2*PRODW-1:PRODW]);
    assign product = s5[PRODW-1:0] + s5[2*PRODW-1:PRODW];
endmodule

// File: rtl/dot_product_mac.sv
// dot_product_mac: streams LEN operand pairs through wallace and accumulates a dot product
module dot_product_mac
    import mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input logic clk,
    input logic rst,
    dot_product_mac_if.slave bus
);
    state_t state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [OPW-1:0] op_a, op_b;
    logic v1, v2;
    logic [PRODW-1:0] prod, prod_q;
    logic [ACC_W-1:0] acc;
    logic ovf;
    logic [ACC_W:0] sum;
    logic accept;
    wallace u_mul (.a(op_a), .b(op_b), .product(prod));
    assign bus.in_ready = (state == RUN) && (remaining != '0);
    assign bus.res_valid = state == DONE;
    assign bus.busy = state != IDLE;
    assign bus.result = acc;
    assign bus.overflow = ovf;
    assign accept = bus.in_ready && bus.in_valid;
    assign sum = {1'b0, acc} + {{(ACC_W + 1 - PRODW){1'b0}}, prod_q};
    // next state: RUN ends once every beat is taken and the last product is leaving stage 2
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = bus.start ? ((bus.len == '0) ? DONE : RUN) : IDLE;
            RUN: state_nxt = (remaining == '0 && !v1) ? DONE : RUN;
            DONE: state_nxt = bus.res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    // operand capture, product register and accumulator; start clears the run totals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            op_a <= '0;
            op_b <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            prod_q <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            prod_q <= prod;
            if (accept) begin
                op_a <= bus.a;
                op_b <= bus.b;
                remaining <= remaining - LEN_W'(1);
            end
            if (state == IDLE && bus.start) begin
                remaining <= bus.len;
                acc <= '0;
                ovf <= 1'b0;
            end else if (v2) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_mac.sv
// tb_dot_product_mac: checks a 24-bit and a 17-bit accumulator instance against a behavioural model
module tb_dot_product_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] len = '0;
    logic in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic res_ready = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    dot_product_mac_if #(.ACC_W(24), .LEN_W(8)) bus24 ();
    dot_product_mac_if #(.ACC_W(17), .LEN_W(8)) bus17 ();

    assign bus24.start = start;
    assign bus24.len = len;
    assign bus24.in_valid = in_valid;
    assign bus24.a = a;
    assign bus24.b = b;
    assign bus24.res_ready = res_ready;
    assign bus17.start = start;
    assign bus17.len = len;
    assign bus17.in_valid = in_valid;
    assign bus17.a = a;
    assign bus17.b = b;
    assign bus17.res_ready = res_ready;

    dot_product_mac #(.ACC_W(24), .LEN_W(8)) u24 (.clk(clk), .rst(rst), .bus(bus24.slave));
    dot_product_mac #(.ACC_W(17), .LEN_W(8)) u17 (.clk(clk), .rst(rst), .bus(bus17.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: sums are kept as plain integers, the result is observable only outside a run
    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
    mphase_e m_ph;
    int m_rem, m_tail;
    longint m_acc24, m_acc17;
    bit m_ovf24, m_ovf17;

    function automatic longint wrap(input longint s, input int w);
        return s % (longint'(1) << w);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= M_IDLE;
            m_rem <= 0;
            m_tail <= 0;
            m_acc24 <= 0;
            m_acc17 <= 0;
            m_ovf24 <= 0;
            m_ovf17 <= 0;
        end else begin
            case (m_ph)
                M_IDLE: if (start) begin
                    m_acc24 <= 0;
                    m_acc17 <= 0;
                    m_ovf24 <= 0;
                    m_ovf17 <= 0;
                    m_rem <= int'(len);
                    m_ph <= (len == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (m_rem != 0) begin
                    if (in_valid) begin
                        m_acc24 <= wrap(m_acc24 + longint'(a) * longint'(b), 24);
                        m_acc17 <= wrap(m_acc17 + longint'(a) * longint'(b), 17);
                        if (m_acc24 + longint'(a) * longint'(b) >= (longint'(1) << 24)) m_ovf24 <= 1;
                        if (m_acc17 + longint'(a) * longint'(b) >= (longint'(1) << 17)) m_ovf17 <= 1;
                        m_rem <= m_rem - 1;
                        m_tail <= 2;
                    end
                end else begin
                    m_tail <= m_tail - 1;
                    if (m_tail == 1) m_ph <= M_DONE;
                end
                M_DONE: if (res_ready) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    // every falling edge: handshake/status outputs always, result/overflow whenever not mid-run
    always @(negedge clk) begin
        check("busy24", bus24.busy, m_ph != M_IDLE);
        check("busy17", bus17.busy, m_ph != M_IDLE);
        check("in_ready24", bus24.in_ready, m_ph == M_RUN && m_rem != 0);
        check("in_ready17", bus17.in_ready, m_ph == M_RUN && m_rem != 0);
        check("res_valid24", bus24.res_valid, m_ph == M_DONE);
        check("res_valid17", bus17.res_valid, m_ph == M_DONE);
        if (m_ph != M_RUN) begin
            check("result24", bus24.result, m_acc24);
            check("result17", bus17.result, m_acc17);
            check("overflow24", bus24.overflow, m_ovf24);
            check("overflow17", bus17.overflow, m_ovf17);
        end
    end

    task automatic begin_run(input int n);
        start = 1'b1;
        len = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic bubble(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name, input longint r24, input longint r17, input bit o24, input bit o17);
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !bus24.res_valid; t++) @(negedge clk);
        check({name, "_done"}, bus24.res_valid, 1);
        check({name, "_r24"}, bus24.result, r24);
        check({name, "_r17"}, bus17.result, r17);
        check({name, "_o24"}, bus24.overflow, o24);
        check({name, "_o17"}, bus17.overflow, o17);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", bus24.busy, 0);
        check("rst_res_valid", bus24.res_valid, 0);
        check("rst_result", bus24.result, 0);
        rst = 1'b0;
        @(negedge clk);
        // basic: 3*4 + 5*6 + 7*8 = 98
        begin_run(3);
        send(3, 4);
        send(5, 6);
        send(7, 8);
        in_valid = 1'b0;
        @(negedge clk);
        check("basic_no_rv_early", bus24.res_valid, 0);
        wait_done("basic", 98, 98, 0, 0);
        @(negedge clk);
        check("basic_idle", bus24.busy, 0);
        // bubbles with garbage operands while in_valid is low
        begin_run(3);
        send(3, 4);
        bubble(2);
        send(5, 6);
        bubble(2);
        send(7, 8);
        wait_done("bubble", 98, 98, 0, 0);
        @(negedge clk);
        // zero length goes straight to DONE
        begin_run(0);
        check("zero_rv", bus24.res_valid, 1);
        wait_done("zero", 0, 0, 0, 0);
        @(negedge clk);
        // overflow: 3*65025 = 195075; 17-bit wraps to 64003
        begin_run(3);
        send(255, 255);
        send(255, 255);
        send(255, 255);
        wait_done("ovf", 195075, 64003, 0, 1);
        @(negedge clk);
        begin_run(1);
        send(2, 2);
        wait_done("ovf_clear", 4, 4, 0, 0);
        @(negedge clk);
        // back-pressure with a stray start in DONE: 1*2 + 3*4 = 14
        res_ready = 1'b0;
        begin_run(2);
        send(1, 2);
        send(3, 4);
        wait_done("bp", 14, 14, 0, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            len = 8'd5;
            @(negedge clk);
            check("bp_hold_rv", bus24.res_valid, 1);
            check("bp_hold_res", bus24.result, 14);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rv", bus24.res_valid, 0);
        check("bp_release_busy", bus24.busy, 0);
        // reset mid-run discards the partial sum
        begin_run(4);
        send(9, 9);
        send(8, 8);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy24", bus24.busy, 0);
        check("mid_rst_in_ready24", bus24.in_ready, 0);
        check("mid_rst_rv24", bus24.res_valid, 0);
        check("mid_rst_result24", bus24.result, 0);
        check("mid_rst_result17", bus17.result, 0);
        check("mid_rst_ovf17", bus17.overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        begin_run(1);
        send(10, 10);
        wait_done("after_rst", 100, 100, 0, 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dot_product_mac.md
Name: dot_product_mac

Overview:
- Sequential multiply-accumulate stage built around the existing 8x8 combinational `wallace` multiplier. It sits directly downstream of that multiplier and consumes its 16-bit product.
- Accepts a stream of LEN unsigned 8-bit operand pairs through a valid/ready handshake.
- Registers each operand pair into the multiplier, registers the product, and accumulates it.
- Presents the dot-product result through a second valid/ready handshake.

Parameters:
- ACC_W, 24, accumulator/result width. Legal range 16..32. The default holds 255 terms of 255*255 without overflow.
- LEN_W, 8, width of the term-count input. Maximum vector length is 2^LEN_W-1.

Ports:
- clk  input  1  single clock; all flops are rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new dot product; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs; sampled with start.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block accepts a/b this cycle.
- a  input  8  unsigned operand A.
- b  input  8  unsigned operand B.
- res_valid  output  1  result is valid and held stable.
- res_ready  input  1  downstream consumes the result.
- result  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- overflow  output  1  sticky flag: an accumulation carried out of ACC_W bits during this run.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; acc, remaining, operand registers, product register and pipe valids all cleared.
  - Outputs: in_ready=0, res_valid=0, result=0, overflow=0, busy=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=0.
  - start with len!=0: on the edge, remaining=len, acc=0, overflow=0, go to RUN.
  - start with len==0: on the edge, acc=0, overflow=0, go directly to DONE, so res_valid is high the next cycle with result 0.
- RUN:
  - in_ready = (remaining!=0), a combinational decode of registered state only, with no dependency on in_valid.
  - A beat is accepted when in_valid && in_ready. On that edge: op_a=a, op_b=b, v1=1, remaining decrements.
  - in_valid while in_ready=0 is ignored; no beat is consumed.
- Pipeline:
  - Stage 1: the operand registers feed the `wallace` instance.
  - Stage 2: on the next edge, prod_q = product (16 b) and v2 = v1.
  - Stage 3: on the next edge, if v2 then acc = acc + zero-extended prod_q.
  - Latency: a beat accepted on edge E reaches acc on edge E+2.
  - Gaps in in_valid insert bubbles; bubbles never modify acc.
- Leaving RUN:
  - When remaining==0, v1==0 and v2 is being consumed on this edge (or is already 0), go to DONE on that same edge.
  - If the last beat is accepted on edge E, res_valid rises after edge E+2.
- Overflow:
  - If the ACC_W+1-bit sum has its MSB set, set overflow. It stays set until the next accepted start.
  - acc wraps modulo 2^ACC_W.
- DONE:
  - res_valid=1; result=acc and overflow are held stable; in_ready=0.
  - On res_valid && res_ready, return to IDLE on that edge. result and overflow keep their last values in IDLE.
  - res_ready held low stalls DONE indefinitely with no change to result.
- start asserted in RUN or DONE is ignored, with no effect on any register.
- Reset asserted mid-run aborts immediately: the partial acc is discarded, and no res_valid is produced for the aborted run.
- result is driven from the acc register only, with no combinational path from any input.

Decomposition:
- Shared package `mac_pkg` holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constant OPW=8 (operand width);
  - constant PRODW=16 (product width).
- Sub-module: the existing `wallace` multiplier, instantiated unmodified between stage 1 and stage 2. No other sub-module.

Test Plan:
- Basic: start len=3; beats (3,4), (5,6), (7,8) on consecutive cycles; res_ready=1 -> res_valid rises 2 edges after the last accept; result=98; overflow=0; back in IDLE 1 cycle later.
- Bubbles: same vector with in_valid deasserted for 2 cycles between beats -> result=98, and a/b changes during in_valid=0 are ignored.
- Zero length: start len=0 -> no beats accepted; res_valid next cycle with result=0 and overflow=0.
- Overflow: ACC_W=17, len=3, three beats of (255,255) -> result=64003 (195075-131072), overflow=1; a following run with len=1, beat (2,2) -> result=4, overflow=0.
- Back-pressure and stray start: hold res_ready=0 for 5 cycles in DONE and pulse start -> result stable, state stays DONE; release res_ready -> one handshake, then IDLE.
- Reset mid-run: len=4, assert rst after 2 accepted beats -> all outputs 0 immediately; new run len=1 with beat (10,10) -> result=100.
